// File: rtl/spike_argmax_classifier.sv
// Output stage of the SNN path: counts per-channel spikes over one frame, then runs a
// sequential argmax scan and presents winner, count, margin and confidence via valid/ready.
module spike_argmax_classifier #(
    parameter int unsigned OUTPUT_SIZE   = 10,
    parameter int unsigned OUTPUT_WIDTH  = 4,
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned TIE_HIGH      = 0,
    parameter int unsigned MIN_MARGIN    = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [OUTPUT_SIZE-1:0]   spike,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUTPUT_WIDTH-1:0]  result,
    output logic [COUNTER_WIDTH-1:0] max_count,
    output logic [COUNTER_WIDTH-1:0] margin,
    output logic                     no_spike,
    output logic                     confident,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [1:0] {StIdle, StAccum, StScan, StHold} state_e;

    localparam logic [COUNTER_WIDTH-1:0] CntMax     = '1;
    localparam logic [OUTPUT_WIDTH-1:0]  LastK      = OUTPUT_WIDTH'(OUTPUT_SIZE - 1);
    localparam logic [COUNTER_WIDTH:0]   MinMarginW = (COUNTER_WIDTH + 1)'(MIN_MARGIN);

    state_e                   state_q;
    logic [COUNTER_WIDTH-1:0] cnt_q   [OUTPUT_SIZE];
    logic [COUNTER_WIDTH-1:0] cnt_inc [OUTPUT_SIZE];
    logic [OUTPUT_WIDTH-1:0]  scan_k_q;
    logic [COUNTER_WIDTH-1:0] best_q, second_q;
    logic [OUTPUT_WIDTH-1:0]  idx_q;

    logic [COUNTER_WIDTH-1:0] cur_cnt;
    logic [COUNTER_WIDTH-1:0] best_d, second_d, diff_d;
    logic [OUTPUT_WIDTH-1:0]  idx_d;
    logic                     take_best;
    logic                     accept;

    assign in_ready = (state_q == StIdle) || (state_q == StAccum);
    assign accept   = in_valid && in_ready;

    // Saturating increment: a full counter holds at its maximum instead of wrapping.
    always_comb begin
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            cnt_inc[i] = cnt_q[i];
            if (spike[i] && (cnt_q[i] != CntMax)) begin
                cnt_inc[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (scan_k_q == OUTPUT_WIDTH'(i)) begin
                cur_cnt = cnt_q[i];
            end
        end
    end

    assign take_best = (TIE_HIGH != 0) ? (cur_cnt >= best_q) : (cur_cnt > best_q);

    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        if (take_best) begin
            second_d = best_q;
            best_d   = cur_cnt;
            idx_d    = scan_k_q;
        end else if (cur_cnt > second_q) begin
            second_d = cur_cnt;
        end
    end

    assign diff_d = best_d - second_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            scan_k_q  <= '0;
            best_q    <= '0;
            second_q  <= '0;
            idx_q     <= '0;
            result    <= '0;
            max_count <= '0;
            margin    <= '0;
            no_spike  <= 1'b0;
            confident <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StAccum;
                        cnt_q   <= cnt_inc;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                    end else begin
                        // Frame end cycle: nothing counted, scan starts next cycle.
                        state_q  <= StScan;
                        scan_k_q <= '0;
                        best_q   <= '0;
                        second_q <= '0;
                        idx_q    <= '0;
                    end
                end
                StScan: begin
                    best_q   <= best_d;
                    second_q <= second_d;
                    idx_q    <= idx_d;
                    scan_k_q <= scan_k_q + 1'b1;
                    if (scan_k_q == LastK) begin
                        result    <= idx_d;
                        max_count <= best_d;
                        margin    <= diff_d;
                        no_spike  <= (best_d == '0);
                        confident <= (best_d != '0) && ({1'b0, diff_d} >= MinMarginW);
                        out_valid <= 1'b1;
                        state_q   <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                        for (int i = 0; i < OUTPUT_SIZE; i++) begin
                            cnt_q[i] <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/spike_argmax_classifier.md
Name: spike_argmax_classifier

Overview:
- Output stage of the SNN inference path. Counts per-channel output spikes over one inference frame, which is a contiguous run of accepted in_valid cycles.
- At frame end it performs a sequential argmax scan over the channel counters, one channel per cycle.
- Reports the winning class, its spike count, the margin over the runner-up, and a confidence flag, all through a valid/ready handshake.
- Back-pressures the spike source while the scan and result hold are in progress.

Parameters:
OUTPUT_SIZE, 10, number of output channels/classes (>=1)
OUTPUT_WIDTH, 4, width of result index; must satisfy 2**OUTPUT_WIDTH >= OUTPUT_SIZE
COUNTER_WIDTH, 8, width of each spike counter, max_count and margin
TIE_HIGH, 0, tie-break: 0 = lowest index wins, 1 = highest index wins
MIN_MARGIN, 1, minimum margin (in spikes) for confident=1

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
spike  input  OUTPUT_SIZE  per-channel spike this cycle
in_valid  input  1  spike vector valid; frame active while high
in_ready  output  1  block accepting spikes
result  output  OUTPUT_WIDTH  winning channel index
max_count  output  COUNTER_WIDTH  spike count of winner
margin  output  COUNTER_WIDTH  winner count minus runner-up count
no_spike  output  1  all counters zero at frame end
confident  output  1  !no_spike && margin >= MIN_MARGIN
out_valid  output  1  result bundle valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE; all counters=0; result=0, max_count=0, margin=0, no_spike=0, confident=0, out_valid=0.
  - Reset mid-frame or mid-scan aborts all activity; no partial result is ever emitted.
- in_ready is decoded from the state: 1 in IDLE/ACCUM, 0 in SCAN/HOLD. Its value during reset is don't-care; it is 1 in the first cycle after reset.
- Accept condition: in_valid && in_ready.
- IDLE:
  - An accept moves the FSM to ACCUM, and that cycle's spikes are counted.
  - in_valid=1 with spike all-zero still starts a frame.
- ACCUM:
  - Each accept: counter[i] += spike[i], saturating at 2**COUNTER_WIDTH-1 (no wrap).
  - First cycle with in_valid=0 (call it cycle T) moves the FSM to SCAN. Nothing is counted in cycle T.
- SCAN: occupies cycles T+1 .. T+OUTPUT_SIZE, processing channel k = 0..OUTPUT_SIZE-1 in order.
  - On entry: best=0, second=0, idx=0.
  - TIE_HIGH=0: if cnt>best then {second=best, best=cnt, idx=k}; else if cnt>second then second=cnt.
  - TIE_HIGH=1: same rule, but the first comparison is cnt>=best.
  - After the last channel, register result=idx, max_count=best, margin=best-second, no_spike=(best==0), confident, and go to HOLD.
- HOLD:
  - out_valid=1 from cycle T+OUTPUT_SIZE+1; the result bundle is stable while out_valid=1.
  - On the edge where out_valid && out_ready, clear all counters, drop out_valid, and go to IDLE. in_ready=1 in the following cycle.
  - If out_ready is already high in the first HOLD cycle, out_valid is a single-cycle pulse.
  - Output registers keep their last values after the handshake.
- in_valid=1 while in_ready=0 is ignored: no counting, no frame start. The source must hold data until in_ready.
- All-zero frame: TIE_HIGH=0 gives result=0; TIE_HIGH=1 gives result=OUTPUT_SIZE-1. In both cases max_count=0, margin=0, no_spike=1, confident=0.
- Tie for the maximum: margin=0, confident=0 (given MIN_MARGIN>=1).
- OUTPUT_SIZE=1: margin=max_count.
- Saturated counters compare as equal at the maximum value.
- Minimum turnaround, frame end to next frame start: OUTPUT_SIZE+2 cycles, with out_ready held high.

Test Plan:
- Defaults; 5-cycle frame, spike[3]=1 every cycle, spike[7]=1 in 2 cycles; in_valid falls at T, out_ready=1 -> out_valid pulse at T+11: result=3, max_count=5, margin=3, confident=1, no_spike=0.
- Tie: ch2 and ch6 each 4 spikes -> TIE_HIGH=0 gives result=2, margin=0, confident=0; TIE_HIGH=1 gives result=6.
- Empty frame: 3 cycles in_valid=1 with spike=0 -> result=0, max_count=0, no_spike=1, confident=0.
- Saturation: COUNTER_WIDTH=4, ch1 spikes 20 cycles, ch0 spikes 3 cycles -> max_count=15, margin=12, result=1; no wrap to 4.
- Back-pressure: out_ready=0 for 6 cycles after out_valid -> bundle stable, in_ready=0, and an in_valid pulse during HOLD is ignored. Raise out_ready -> counters cleared, next frame counts from 0.
- Reset mid-SCAN (rstn=0 at cycle T+4) -> out_valid never asserts, counters=0, in_ready=1 after reset, next frame scores correctly.
